// File: rtl/video_upscaler_2x2.sv
// 2x2 nearest-neighbour video upscaler: live pass-through line, then line-buffer replay.
// Define UPSCALER_OVF_FLAG_EN to add the sticky line_ovf output.
module video_upscaler_2x2 #(
  parameter  int D_WIDTH      = 8,
  parameter  int MAX_LINE_PIX = 1024,
  localparam int ADDR_W       = $clog2(MAX_LINE_PIX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
`ifdef UPSCALER_OVF_FLAG_EN
  output logic               line_ovf,
`endif
  input  logic               down_ready
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MAX_LINE_PIX - 1);
  localparam logic [ADDR_W-1:0] ZERO_A = '0;

  typedef enum logic {
    FILL,
    REPLAY
  } state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_ptr_q, last_ptr_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;

  logic [D_WIDTH-1:0] mem_q [MAX_LINE_PIX];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              out_hs;

  // Output muxing and next-state: live pass in FILL, buffer replay in REPLAY
  always_comb begin
    up_ready   = 1'b0;
    down_valid = 1'b0;
    down_data  = up_data;
    down_tlast = 1'b0;
    down_tuser = 1'b0;
    state_d    = state_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_ptr_d = last_ptr_q;
    ovf_d      = ovf_q;
    full_d     = full_q;
    we         = 1'b0;
    waddr      = wr_ptr_q;
    out_hs     = 1'b0;
    if (rst) begin
      case (state_q)
        FILL: begin
          down_valid = up_valid;
          up_ready   = down_ready & phase_q;
          down_tlast = up_tlast & phase_q;
          down_tuser = up_tuser & ~phase_q;
          out_hs     = up_valid & down_ready;
          if (out_hs && !phase_q) begin
            phase_d = 1'b1;
            // tuser mid-line restarts the line at slot 0
            if (up_tuser && wr_ptr_q != ZERO_A) begin
              waddr    = ZERO_A;
              wr_ptr_d = ZERO_A;
              full_d   = 1'b0;
            end
            // last slot already holds a pixel: drop and flag
            if (waddr == LAST_A && full_q) begin
              ovf_d = 1'b1;
            end else begin
              we = 1'b1;
              if (waddr == LAST_A) full_d = 1'b1;
            end
          end else if (out_hs) begin
            phase_d = 1'b0;
            if (up_tlast) begin
              last_ptr_d = wr_ptr_q;
              rd_ptr_d   = ZERO_A;
              state_d    = REPLAY;
            end else if (wr_ptr_q != LAST_A) begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        REPLAY: begin
          down_valid = 1'b1;
          down_data  = mem_q[rd_ptr_q];
          down_tlast = (rd_ptr_q == last_ptr_q) & phase_q;
          if (down_ready) begin
            phase_d = ~phase_q;
            if (phase_q) begin
              if (rd_ptr_q == last_ptr_q) begin
                state_d  = FILL;
                phase_d  = 1'b0;
                wr_ptr_d = ZERO_A;
                rd_ptr_d = ZERO_A;
                ovf_d    = 1'b0;
                full_d   = 1'b0;
              end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
              end
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      phase_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_ptr_q <= '0;
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_ptr_q <= last_ptr_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
    end
  end

  // Line buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= up_data;
  end

`ifdef UPSCALER_OVF_FLAG_EN
  logic line_ovf_q;

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) line_ovf_q <= 1'b0;
    else      line_ovf_q <= line_ovf_q | ovf_d;
  end

  assign line_ovf = line_ovf_q;
`endif

endmodule

// File: tb/tb_video_upscaler_2x2.sv
// Scoreboard bench for video_upscaler_2x2 with a queue-based line model.
// Built with MAX_LINE_PIX=4 so overflow and truncation are reachable.
module tb_video_upscaler_2x2;

  localparam int DW   = 8;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_tlast = 1'b0;
  logic          up_tuser = 1'b0;
  logic          up_ready;
  logic [DW-1:0] down_data;
  logic          down_valid;
  logic          down_tlast;
  logic          down_tuser;
  logic          down_ready = 1'b1;
`ifdef UPSCALER_OVF_FLAG_EN
  logic          line_ovf;
`endif

  video_upscaler_2x2 #(
    .D_WIDTH     (DW),
    .MAX_LINE_PIX(MAXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_tlast  (up_tlast),
    .up_tuser  (up_tuser),
    .up_ready  (up_ready),
    .down_data (down_data),
    .down_valid(down_valid),
    .down_tlast(down_tlast),
    .down_tuser(down_tuser),
`ifdef UPSCALER_OVF_FLAG_EN
    .line_ovf  (line_ovf),
`endif
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          user;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] lb[$];
  logic          model_ovf = 1'b0;
  logic [DW-1:0] pix[16];
  logic          usr[16];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  bit            rand_rdy = 1'b0;

  // Downstream ready: always 1 or a random 50% pattern
  always @(posedge clk) begin
    #1;
    down_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  beat_t held;
  bit    held_v = 1'b0;

  // Monitor: pop-and-compare on each output handshake, check stability while stalled
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && down_valid) begin
        n_tests++;
        if (down_data !== held.d || down_tlast !== held.last || down_tuser !== held.user) begin
          n_fail++;
          $display("FAIL stall_stable: got d=%h l=%b u=%b, held d=%h l=%b u=%b",
                   down_data, down_tlast, down_tuser, held.d, held.last, held.user);
        end
      end
      if (down_valid && down_ready) begin
        n_tests++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat %0d: got d=%h l=%b u=%b, expected no beat",
                   n_out, down_data, down_tlast, down_tuser);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (down_data !== e.d || down_tlast !== e.last || down_tuser !== e.user) begin
            n_fail++;
            $display("FAIL out_beat %0d: got d=%h l=%b u=%b, expected d=%h l=%b u=%b",
                     n_out, down_data, down_tlast, down_tuser, e.d, e.last, e.user);
          end
        end
      end
      held_v = down_valid && !down_ready;
      held   = '{d: down_data, last: down_tlast, user: down_tuser};
    end
  end

  // Reference: each pixel doubled live, then the buffered line doubled again
  task automatic push_replay();
    for (int k = 0; k < lb.size(); k++) begin
      exp_q.push_back('{d: lb[k], last: 1'b0, user: 1'b0});
      exp_q.push_back('{d: lb[k], last: (k == lb.size() - 1), user: 1'b0});
    end
    lb.delete();
  endtask

  task automatic drive_line(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps && $urandom_range(0, 3) == 0) begin
        up_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (usr[i] && lb.size() != 0) lb.delete();
      if (lb.size() < MAXP) lb.push_back(pix[i]);
      else model_ovf = 1'b1;
      exp_q.push_back('{d: pix[i], last: 1'b0, user: usr[i]});
      exp_q.push_back('{d: pix[i], last: (i == n - 1), user: 1'b0});
      up_data  = pix[i];
      up_tlast = (i == n - 1);
      up_tuser = usr[i];
      up_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!up_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!up_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: pixel %0d not accepted, got up_ready=%b, required 1",
                 i, up_ready);
        up_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
`ifdef UPSCALER_OVF_FLAG_EN
      n_tests++;
      if (line_ovf !== model_ovf) begin
        n_fail++;
        $display("FAIL line_ovf after pixel %0d: got %b, required %b", i, line_ovf, model_ovf);
      end
`endif
    end
    up_valid = 1'b0;
    push_replay();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (down_valid !== 1'b0 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got down_valid=%b up_ready=%b, required 0 0",
               tag, down_valid, up_ready);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    up_valid = 1'b1;
    up_data  = 8'h33;
    #2;
    check_reset_outputs("reset_hold");
    repeat (3) @(posedge clk);
    up_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 4x2 frame, values 1..8, ready held high then randomized
    for (int pass = 0; pass < 2; pass++) begin
      rand_rdy = (pass == 1);
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < 4; i++) begin
          pix[i] = 8'(r * 4 + i + 1);
          usr[i] = (r == 0 && i == 0);
        end
        drive_line(4, 1'b0);
      end
      drain();
    end

    // Single-pixel line
    rand_rdy = 1'b0;
    pix[0] = 8'hA5;
    usr[0] = 1'b0;
    drive_line(1, 1'b0);
    drain();

    // Line longer than the buffer: live pass intact, replay truncated
    for (int i = 0; i < 6; i++) begin
      pix[i] = 8'(i + 1);
      usr[i] = 1'b0;
    end
    drive_line(6, 1'b0);
    drain();

    // tuser at the 3rd pixel restarts the buffered line
    rand_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix[i] = 8'(8'h40 + i);
      usr[i] = (i == 2);
    end
    drive_line(5, 1'b1);
    drain();

    // Random lines, random data, gaps, back-pressure
    for (int l = 0; l < 24; l++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pix[i] = 8'($urandom);
        usr[i] = ($urandom_range(0, 7) == 0);
      end
      drive_line(n, 1'b1);
    end
    drain();

    // Reset in the middle of replaying line 2
    rand_rdy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        pix[i] = 8'(8'h10 * (r + 1) + i);
        usr[i] = (r == 0 && i == 0);
      end
      drive_line(4, 1'b0);
    end
    repeat (3) @(posedge clk);
    up_valid = 1'b1;
    up_data  = 8'hEE;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_replay");
    exp_q.delete();
    lb.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_hold");
    up_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pix[i] = 8'(8'hC0 + i);
      usr[i] = (i == 0);
    end
    drive_line(3, 1'b0);
    drain();

    n_tests++;
    if (n_out < 100) begin
      n_fail++;
      $display("FAIL beat_count: got %0d output beats, required at least 100", n_out);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_upscaler_2x2.md
Name: video_upscaler_2x2

Overview:
- 2x2 nearest-neighbour upscaler on the AXI-stream-like video bus (data/valid/ready/tlast/tuser).
- Each input pixel is emitted twice horizontally. Each input line is emitted twice vertically: the first pass is fed live from the input, the second is replayed from an internal line buffer.
- Sits downstream of the video source, mirroring the 2x2 decimator at the other end of the pipeline.

Parameters:
- D_WIDTH, 8, pixel data width in bits.
- MAX_LINE_PIX, 1024, maximum input pixels per line held in the line buffer (power of two, >=2).
- ADDR_W, $clog2(MAX_LINE_PIX), line-buffer pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- up_data  in  D_WIDTH  input pixel.
- up_valid  in  1  input beat valid.
- up_tlast  in  1  last pixel of input line.
- up_tuser  in  1  first pixel of input frame.
- up_ready  out  1  block accepts input beat.
- down_data  out  D_WIDTH  output pixel.
- down_valid  out  1  output beat valid.
- down_tlast  out  1  last pixel of output line.
- down_tuser  out  1  first pixel of output frame.
- down_ready  in  1  downstream accepts beat.

Behaviour:
- Handshake: a beat transfers when valid & ready on a rising edge. Output valid never waits on down_ready.
- State: FILL or REPLAY. Sub-state: phase bit (0 = first copy, 1 = second copy).
- Reset (rst=0, asynchronous): state=FILL, phase=0, wr_ptr=0, rd_ptr=0, last_ptr=0, ovf=0. While reset is held, up_ready=0 and down_valid=0.
- Reset mid-line discards any partial line and any replay in progress. No output beat completes during reset.

FILL state (combinational pass-through):
- down_data=up_data, down_valid=up_valid.
- up_ready = down_ready & (phase==1). Each input beat is held on the bus for two output beats.
- down_tlast = up_tlast & (phase==1).
- down_tuser = up_tuser & (phase==0).
- On an output handshake with phase=0: write up_data to buf[wr_ptr], then set phase=1.
- On an output handshake with phase=1: set phase=0 and consume the input beat.
  - If up_tlast: last_ptr=wr_ptr, state=REPLAY, rd_ptr=0.
  - Otherwise: wr_ptr=wr_ptr+1, saturating at MAX_LINE_PIX-1.
- up_tuser accepted while wr_ptr!=0 forces wr_ptr=0 before the write (frame resync). tuser is still forwarded.

REPLAY state:
- up_ready=0, down_valid=1, down_data=buf[rd_ptr]. The buffer has combinational read.
- down_tuser=0.
- down_tlast = (rd_ptr==last_ptr) & (phase==1).
- On each output handshake phase toggles. On a phase=1 handshake rd_ptr increments.
- On the handshake where tlast=1: state=FILL, wr_ptr=0, rd_ptr=0, phase=0.

Overflow:
- A write attempted with wr_ptr already at MAX_LINE_PIX-1 and a pixel already stored there sets ovf=1.
- The data is dropped and the buffer keeps its last stored pixel.
- The live pass is unaffected.
- The replay line is truncated to MAX_LINE_PIX pixels, doubled.
- ovf clears when the next FILL begins.

Throughput and sizing:
- Throughput: 1 output beat per cycle when down_ready=1.
- Input acceptance averages 1 beat per 4 output cycles.
- Output line length = 2 x input length; output frame height = 2 x input height.
- Latency: zero cycles in FILL (combinational).
- Back-pressure: down_ready=0 freezes phase, pointers and state, and down_data/down_tlast/down_tuser are held stable.

Optional Feature:
- Macro: UPSCALER_OVF_FLAG_EN.
- Defined: adds output port line_ovf (1 bit), a registered sticky flag.
  - Set on any overflow event.
  - Cleared only by reset.
  - Reset value 0.
- Undefined: no port. Truncation behaviour on overflow is identical.

Test Plan:
- Reset, then 1 frame of 4x2 pixels (values 1..8), down_ready=1. Required output: 8x4 pixels.
  - Rows 1 and 2 = 1,1,2,2,3,3,4,4.
  - Rows 3 and 4 = 5,5,6,6,7,7,8,8.
  - tlast on every 8th beat; tuser only on the first beat.
- Same stimulus with down_ready toggling in a random 50% pattern -> identical output sequence, no dropped or duplicated beats, outputs stable while stalled.
- Line of 1 pixel (value 0xA5, tlast=1) -> 4 beats of 0xA5, with tlast on beats 2 and 4.
- MAX_LINE_PIX=4, input line of 6 pixels (1..6) -> live pass 1,1,...,6,6 (12 beats), replay 1,1,2,2,3,3,4,4 (8 beats).
  - With UPSCALER_OVF_FLAG_EN: line_ovf=1 after the 5th input pixel.
- Assert rst=0 mid-REPLAY of line 2 -> down_valid and up_ready drop to 0 immediately. After release, the next line starts in FILL with wr_ptr=0 and correct doubling.
- up_tuser asserted at the 3rd pixel of a line -> wr_ptr restarts at 0 and that pixel is replayed first.
